uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- Standalone oversampling UART receiver; the receive-side counterpart to the team's Tx_top serial framer.
- Frame format: 1 start bit, INPUT_DATA_WIDTH data bits LSB-first, optional even-parity bit, 1 stop bit.
- Samples serial_in at CLKS_PER_BIT clocks per bit, rejects start-bit glitches, and flags parity and framing errors.
- Instantiated in the UART receive path and in Tx/Rx loopback benches.

Parameters:
- INPUT_DATA_WIDTH, 8, number of data bits per frame.
- PARITY_ENABLED, 1, 1 = even-parity bit present after the data bits; 0 = no parity bit.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.

Ports:
- clk  input  1  receiver clock, CLKS_PER_BIT x baud rate.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous serial line; idle high.
- received_data  output  INPUT_DATA_WIDTH  last frame's data bits, LSB = first data bit received.
- data_is_valid  output  1  one-cycle pulse: error-free frame captured.
- rx_error  output  1  one-cycle pulse: parity or framing error on the completed frame.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: received_data=0, data_is_valid=0, rx_error=0, o_busy=0, state=IDLE, counters=0.
- Synchronizer: both synchronizer flops reset to 1. All logic uses the synchronized value (rx_s); the 2-cycle synchronizer delay is accepted.
- A reset asserted mid-frame aborts the frame, returns to IDLE, and produces no pulse.
- Counters: sample_cnt (clog2(CLKS_PER_BIT) bits) and bit_idx (clog2(INPUT_DATA_WIDTH) bits).
- IDLE: when rx_s==0, go to START with sample_cnt=0.
- START:
  - Increment sample_cnt.
  - At sample_cnt==CLKS_PER_BIT/2-1, check rx_s.
  - rx_s==1: glitch; return to IDLE with no output.
  - rx_s==0: clear sample_cnt, bit_idx=0, go to DATA. The sample point is now mid-bit.
- DATA:
  - At sample_cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of shift_reg (right-shift), clear sample_cnt, increment bit_idx.
  - After bit INPUT_DATA_WIDTH-1: go to PARITY if PARITY_ENABLED, else STOP.
- PARITY: at sample_cnt==CLKS_PER_BIT-1, set parity_err = rx_s XOR (^shift_reg), then go to STOP.
- STOP: at sample_cnt==CLKS_PER_BIT-1, evaluate the stop bit.
  - rx_s==1 and !parity_err: load received_data from shift_reg and pulse data_is_valid for 1 cycle. Return to IDLE.
  - rx_s==1 and parity_err: pulse rx_error for 1 cycle. received_data is unchanged. Return to IDLE.
  - rx_s==0: framing error. Pulse rx_error for 1 cycle; received_data is unchanged. Go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering START.
- Output timing: data_is_valid and rx_error assert in the clk cycle after the stop-bit sample. They are never high together.
- Latency: from the serial_in falling edge to data_is_valid = 2 + CLKS_PER_BIT/2 + (INPUT_DATA_WIDTH+PARITY_ENABLED+1)*CLKS_PER_BIT + 1 clk cycles (±1 cycle for edge alignment).
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge one stop-bit later is detected with no dead time.
- All counters wrap only by explicit clear; no free-running wrap.

Test Plan:
- Reset, line idle high for 100 clk cycles -> outputs stay 0, o_busy=0.
- Frame 0xA5, parity bit 0, stop bit 1, CLKS_PER_BIT=16 -> single data_is_valid pulse, received_data=0xA5, rx_error=0.
- Frame 0xA5 with parity bit 1 -> rx_error pulse, data_is_valid=0, received_data keeps the previous value 0xA5 from the earlier frame.
- Stop bit driven 0, then line held low 50 bits, then released -> one rx_error pulse, stays in BREAK_WAIT, no further pulses until after release.
- Low glitch of 5 clk cycles on idle line -> returns to IDLE, no pulses; a following valid 0x3C frame is received correctly.
- Frames 0x00, 0xFF, 0x55 back-to-back with PARITY_ENABLED=0 -> three data_is_valid pulses in order with matching data; reset asserted mid-second-frame -> no pulse for that frame, next frame received cleanly.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 1 start bit, INPUT_DATA_WIDTH data bits LSB-first,
// optional even-parity bit, 1 stop bit. Start-bit glitches are rejected and
// parity/framing errors are flagged with a one-cycle rx_error pulse.
module uart_rx_oversampled #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int CLKS_PER_BIT     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        rx_error,
  output logic                        o_busy
);

  localparam int SW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

  localparam logic [SW-1:0] HALF_LAST = SW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t                      state_q, state_d;
  logic                        sync1_q, sync2_q;
  logic                        rx_s;
  logic [SW-1:0]               sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]               bit_idx_q, bit_idx_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                        parity_err_q, parity_err_d;
  logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  // The line is asynchronous, so everything downstream uses the double-flopped copy.
  assign rx_s = sync2_q;

  // Next-state, counter, shift-register and output-pulse computation for the receive FSM.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_err_d = parity_err_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d      = START;
          sample_cnt_d = '0;
        end
      end

      START: begin
        if (sample_cnt_q == HALF_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d      = DATA;
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            parity_err_d = 1'b0;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end

      DATA: begin
        if (sample_cnt_q == BIT_LAST) begin
          shift_d      = {rx_s, shift_q[INPUT_DATA_WIDTH-1:1]};
          sample_cnt_d = '0;
          if (bit_idx_q == DATA_LAST) begin
            state_d = (PARITY_ENABLED != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end

      PARITY: begin
        if (sample_cnt_q == BIT_LAST) begin
          parity_err_d = rx_s ^ (^shift_q);
          sample_cnt_d = '0;
          state_d      = STOP;
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end

      STOP: begin
        if (sample_cnt_q == BIT_LAST) begin
          sample_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (parity_err_q) begin
              err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end

      BREAK_WAIT: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the synchronizer, updates here; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= serial_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign received_data = data_q;
  assign data_is_valid = valid_q;
  assign rx_error      = err_q;
  assign o_busy        = (state_q != IDLE);

endmodule
